// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, full/empty/threshold flags and a
// combinational head output. Reset is asynchronous and clears the storage too.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int THRESHOLD  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  testmode_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  threshold_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  generate
    if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two >= 1");
    end
    if ((THRESHOLD < 1) || (THRESHOLD > DEPTH)) begin : g_bad_threshold
      $error("sync_fifo: THRESHOLD must lie in 1..DEPTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [PTR_W-1:0]      wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_next;
  logic                  push_eff;
  logic                  pop_eff;
  logic                  unused_testmode;

  // Test-mode is carried on the port for DFT integration only.
  assign unused_testmode = testmode_i;

  assign push_eff = push_i & ~full_o;
  assign pop_eff  = pop_i & ~empty_o;

  // Explicit wrap keeps DEPTH=1 pinned at entry 0.
  assign wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
  assign rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) begin
        mem_reg[wr_ptr_reg] <= data_i;
        wr_ptr_reg          <= wr_ptr_next;
      end
      if (pop_eff) begin
        rd_ptr_reg <= rd_ptr_next;
      end
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign data_o      = mem_reg[rd_ptr_reg];
  assign full_o      = (count_reg == CNT_W'(DEPTH));
  assign empty_o     = (count_reg == '0);
  assign threshold_o = (count_reg >= CNT_W'(THRESHOLD));

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a DEPTH=4/THRESHOLD=2 instance and a
// DEPTH=1 instance, directed corner cases followed by random traffic.
module tb_sync_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       testmode_i;

  logic       a_flush, a_push, a_pop;
  logic [7:0] a_din, a_dout;
  logic       a_full, a_empty, a_thr;

  logic       b_flush, b_push, b_pop;
  logic [7:0] b_din, b_dout;
  logic       b_full, b_empty, b_thr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q[$];

  always #5 clk_i = ~clk_i;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(4), .THRESHOLD(2)) u_fifo_a (
    .clk_i(clk_i), .rst_i(rst_i), .testmode_i(testmode_i), .flush_i(a_flush),
    .push_i(a_push), .data_i(a_din), .pop_i(a_pop), .data_o(a_dout),
    .full_o(a_full), .empty_o(a_empty), .threshold_o(a_thr)
  );

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(1), .THRESHOLD(1)) u_fifo_b (
    .clk_i(clk_i), .rst_i(rst_i), .testmode_i(testmode_i), .flush_i(b_flush),
    .push_i(b_push), .data_i(b_din), .pop_i(b_pop), .data_o(b_dout),
    .full_o(b_full), .empty_o(b_empty), .threshold_o(b_thr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dout(input bit sel);
    return sel ? b_dout : a_dout;
  endfunction

  task automatic check_flags(input bit sel, input string tag);
    int depth = sel ? 1 : 4;
    int thr   = sel ? 1 : 2;
    check({tag, "_empty"}, sel ? b_empty : a_empty, q.size() == 0);
    check({tag, "_full"},  sel ? b_full  : a_full,  q.size() == depth);
    check({tag, "_thr"},   sel ? b_thr   : a_thr,   q.size() >= thr);
    if (q.size() > 0) check({tag, "_head"}, dout(sel), q[0]);
  endtask

  // One clock of stimulus on the selected instance; called at posedge+1.
  task automatic cyc(input bit sel, input bit psh, input bit pp, input bit fl,
                     input logic [7:0] d);
    int depth = sel ? 1 : 4;
    bit push_eff, pop_eff;
    logic [7:0] exp;
    if (sel) begin b_push = psh; b_pop = pp; b_flush = fl; b_din = d; end
    else     begin a_push = psh; a_pop = pp; a_flush = fl; a_din = d; end
    if (fl) begin
      q.delete();
    end else begin
      push_eff = psh && (q.size() < depth);
      pop_eff  = pp && (q.size() > 0);
      if (pop_eff) begin
        exp = q.pop_front();
        check("pop_data", dout(sel), exp);
      end
      if (push_eff) q.push_back(d);
    end
    @(posedge clk_i);
    #1;
    a_push = 0; a_pop = 0; a_flush = 0;
    b_push = 0; b_pop = 0; b_flush = 0;
    $display("txn fifo=%0d push=%0b pop=%0b flush=%0b din=%02h count=%0d", sel ? 1 : 0,
             psh, pp, fl, d, q.size());
    check_flags(sel, "post");
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    q.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    testmode_i = 1'b0;
    a_flush = 0; a_push = 0; a_pop = 0; a_din = '0;
    b_flush = 0; b_push = 0; b_pop = 0; b_din = '0;
    do_reset();

    check("rst_empty", a_empty, 1'b1);
    check("rst_full",  a_full,  1'b0);
    check("rst_thr",   a_thr,   1'b0);
    check("rst_data",  a_dout,  8'h00);
    check("rst_b_data", b_dout, 8'h00);

    // Fill to full, then drain in order.
    cyc(0, 1, 0, 0, 8'h11);
    cyc(0, 1, 0, 0, 8'h22);
    cyc(0, 1, 0, 0, 8'h33);
    cyc(0, 1, 0, 0, 8'h44);
    check("fill_full", a_full, 1'b1);
    repeat (4) cyc(0, 0, 1, 0, 8'h00);
    check("drain_empty", a_empty, 1'b1);

    // Push+pop on a full FIFO: pop only.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 8'(8'h60 + i));
    cyc(0, 1, 1, 0, 8'h55);
    check("fullpp_full", a_full, 1'b0);
    check("fullpp_count3", q.size(), 3);
    repeat (3) cyc(0, 0, 1, 0, 8'h00);

    // Push+pop on an empty FIFO: push only, no fall-through.
    cyc(0, 1, 1, 0, 8'hA5);
    check("emptypp_data", a_dout, 8'hA5);
    check("emptypp_empty", a_empty, 1'b0);
    cyc(0, 0, 1, 0, 8'h00);

    // Threshold edges and flush.
    cyc(0, 1, 0, 0, 8'h01);
    check("thr_at1", a_thr, 1'b0);
    cyc(0, 1, 0, 0, 8'h02);
    check("thr_at2", a_thr, 1'b1);
    cyc(0, 0, 1, 0, 8'h00);
    check("thr_back1", a_thr, 1'b0);
    cyc(0, 1, 0, 0, 8'h03);
    cyc(0, 1, 0, 0, 8'h04);
    cyc(0, 1, 1, 1, 8'h05);
    check("flush_empty", a_empty, 1'b1);
    cyc(0, 1, 0, 0, 8'h06);
    cyc(0, 0, 1, 0, 8'h00);

    // Reset mid-stream with three entries held.
    cyc(0, 1, 0, 0, 8'hC1);
    cyc(0, 1, 0, 0, 8'hC2);
    cyc(0, 1, 0, 0, 8'hC3);
    #2 rst_i = 1'b1;
    #1;
    q.delete();
    check("midrst_empty", a_empty, 1'b1);
    check("midrst_full",  a_full,  1'b0);
    check("midrst_thr",   a_thr,   1'b0);
    check("midrst_data",  a_dout,  8'h00);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    cyc(0, 1, 0, 0, 8'hD1);
    cyc(0, 1, 0, 0, 8'hD2);
    cyc(0, 0, 1, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);

    // Random traffic on the DEPTH=4 instance.
    for (int i = 0; i < 300; i++) begin
      cyc(0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
          $urandom_range(0, 49) == 0, 8'($urandom));
    end

    // DEPTH=1 instance.
    do_reset();
    check("b_rst_empty", b_empty, 1'b1);
    cyc(1, 1, 0, 0, 8'h07);
    check("b_full", b_full, 1'b1);
    check("b_not_empty", b_empty, 1'b0);
    cyc(1, 1, 0, 0, 8'h08);
    check("b_ignored", b_dout, 8'h07);
    cyc(1, 0, 1, 0, 8'h00);
    check("b_empty", b_empty, 1'b1);
    for (int i = 0; i < 100; i++) begin
      cyc(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
